wb_port_arbiter: RTL and testbench

- Shares the processor's single 16-bit register-file write port between two requesters: A (ALU result path) and B (memory load path).
- Arbitrates between them round-robin and steers data through one internal mux16 instance.
- Holds the winning write in a one-entry output register, drained by a valid/ready handshake toward the register file.
- Sits between the execute/memory stages and the register-file write port.

---
 rtl/wb_port_arbiter_pkg.sv | 13 +
 rtl/wb_port_arbiter_if.sv | 37 +++
 rtl/wb_port_arbiter_mux16.sv | 9 +
 rtl/wb_port_arbiter.sv | 93 +++++++++
 tb/tb_wb_port_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
package wb_port_arbiter_pkg;
  localparam int AW = 4;
  localparam int DW = 16;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;
endpackage

// File: rtl/wb_port_arbiter_if.sv
// Requester and register-file write-port bundle for the write-port arbiter.
interface wb_port_arbiter_if;
  import wb_port_arbiter_pkg::*;

  logic          req_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] data_a;
  logic          gnt_a;
  logic          req_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] data_b;
  logic          gnt_b;
  logic          wr_rdy;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          sel;
  logic          busy;

  modport master (
    output req_a, addr_a, data_a,
    output req_b, addr_b, data_b,
    output wr_rdy,
    input  gnt_a, gnt_b,
    input  wr_en, wr_addr, wr_data,
    input  sel, busy
  );

  modport slave (
    input  req_a, addr_a, data_a,
    input  req_b, addr_b, data_b,
    input  wr_rdy,
    output gnt_a, gnt_b,
    output wr_en, wr_addr, wr_data,
    output sel, busy
  );
endinterface

// File: rtl/wb_port_arbiter_mux16.sv
// 16-bit two-input data mux shared by the write-port datapath.
module mux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port between
// the ALU (A) and load (B) paths, with a one-entry output register.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
(
  input logic              clk,
  input logic              rst_f,
  wb_port_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;

  logic          wr_en;
  logic          drain;
  logic          free;
  logic          gnt_a;
  logic          gnt_b;
  logic          sel;
  logic [AW-1:0] addr_mux;
  logic [DW-1:0] data_mux;

  assign wr_en = (state_q == ST_FULL);
  assign drain = wr_en & bus.wr_rdy;
  assign free  = ~wr_en | drain;

  // Held low during reset so a pending request can't win before an edge.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_f && free) begin
      unique case (1'b1)
        bus.req_a & ~bus.req_b: gnt_a = 1'b1;
        bus.req_b & ~bus.req_a: gnt_b = 1'b1;
        bus.req_a & bus.req_b: begin
          gnt_a = (last_q == SEL_B);
          gnt_b = (last_q == SEL_A);
        end
        default: ;
      endcase
    end
  end

  assign sel      = gnt_b ? SEL_B : SEL_A;
  assign addr_mux = (sel == SEL_B) ? bus.addr_b : bus.addr_a;

  mux16 u_mux (
    .a   (bus.data_a),
    .b   (bus.data_b),
    .sel (sel),
    .y   (data_mux)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (gnt_a || gnt_b) begin
      state_d = ST_FULL;
      last_d  = sel;
      addr_d  = addr_mux;
      data_d  = data_mux;
    end else if (drain) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= ST_EMPTY;
      last_q  <= SEL_B;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign bus.gnt_a   = gnt_a;
  assign bus.gnt_b   = gnt_b;
  assign bus.sel     = sel;
  assign bus.wr_en   = wr_en;
  assign bus.wr_addr = addr_q;
  assign bus.wr_data = data_q;
  assign bus.busy    = wr_en & ~bus.wr_rdy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: directed cases plus protocol-legal random traffic.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst_f = 1'b0;

  wb_port_arbiter_if bus();

  wb_port_arbiter dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } item_t;

  int n_vec = 0;
  int n_err = 0;

  item_t q[$];
  logic  m_full = 1'b0;
  logic  m_last = 1'b1;
  int    rst_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  always @(negedge rst_f) begin
    rst_cnt++;
    q.delete();
    m_full = 1'b0;
    m_last = 1'b1;
  end

  // Reference model: expected contents pushed on grant, popped on drain.
  initial begin
    logic  ea, eb, fr, dr;
    int    rc;
    item_t it;
    forever begin
      @(negedge clk);
      if (!rst_f) begin
        chk("rst_wr_en", bus.wr_en, 0);
        chk("rst_wr_addr", bus.wr_addr, 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_gnt", {bus.gnt_a, bus.gnt_b}, 0);
      end else begin
        rc = rst_cnt;
        chk("m_wr_en", bus.wr_en, m_full);
        if (m_full && q.size() > 0) begin
          chk("m_wr_addr", bus.wr_addr, q[0].a);
          chk("m_wr_data", bus.wr_data, q[0].d);
        end
        fr = !m_full || bus.wr_rdy;
        dr = m_full && bus.wr_rdy;
        ea = 1'b0;
        eb = 1'b0;
        if (fr) begin
          if (bus.req_a && bus.req_b) begin
            ea = m_last;
            eb = !m_last;
          end else begin
            ea = bus.req_a;
            eb = bus.req_b;
          end
        end
        chk("m_gnt_a", bus.gnt_a, ea);
        chk("m_gnt_b", bus.gnt_b, eb);
        chk("m_sel", bus.sel, eb);
        chk("m_busy", bus.busy, m_full && !bus.wr_rdy);
        it = eb ? {bus.addr_b, bus.data_b} : {bus.addr_a, bus.data_a};
        @(posedge clk);
        if (rc == rst_cnt) begin
          if (dr) begin
            void'(q.pop_front());
            m_full = 1'b0;
          end
          if (ea || eb) begin
            q.push_back(it);
            m_full = 1'b1;
            m_last = eb;
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] exp_sel;
    logic [DW-1:0] exp_dat [4];
    logic ga, gb;
    exp_sel = 4'b1010;
    exp_dat = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};

    bus.req_a = 0; bus.addr_a = '0; bus.data_a = '0;
    bus.req_b = 0; bus.addr_b = '0; bus.data_b = '0;
    bus.wr_rdy = 1;
    @(negedge clk);
    @(negedge clk);
    cyc();
    rst_f = 1;

    // single A
    bus.req_a = 1; bus.addr_a = 4'h3; bus.data_a = 16'h1234;
    @(negedge clk);
    chk("a_gnt", bus.gnt_a, 1);
    chk("a_sel", bus.sel, 0);
    cyc();
    bus.req_a = 0;
    @(negedge clk);
    chk("a_wr_en", bus.wr_en, 1);
    chk("a_addr", bus.wr_addr, 4'h3);
    chk("a_data", bus.wr_data, 16'h1234);
    cyc();
    @(negedge clk);
    chk("a_idle", bus.wr_en, 0);

    // contention from a fresh reset
    cyc();
    rst_f = 0;
    #2;
    rst_f = 1;
    bus.req_a = 1; bus.addr_a = 4'h1; bus.data_a = 16'hAAAA;
    bus.req_b = 1; bus.addr_b = 4'h2; bus.data_b = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_sel", bus.sel, exp_sel[i]);
      chk("rr_gnt", {bus.gnt_a, bus.gnt_b}, exp_sel[i] ? 2'b01 : 2'b10);
      if (i > 0) chk("rr_data", bus.wr_data, exp_dat[i-1]);
      cyc();
      if (i == 2) bus.req_a = 0;
    end

    // back-pressure
    bus.addr_b = 4'h5; bus.data_b = 16'h7777;
    bus.wr_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_gnt_b", bus.gnt_b, 0);
      chk("bp_busy", bus.busy, 1);
      chk("bp_data", bus.wr_data, 16'h5555);
      cyc();
    end
    bus.wr_rdy = 1;
    @(negedge clk);
    chk("bp_release", bus.gnt_b, 1);
    cyc();

    // drain and refill in one cycle
    bus.req_b = 0;
    bus.req_a = 1; bus.addr_a = 4'h6; bus.data_a = 16'h4321;
    @(negedge clk);
    chk("df_data0", bus.wr_data, 16'h7777);
    chk("df_gnt_a", bus.gnt_a, 1);
    cyc();

    // single B after A, then A-only again
    bus.req_a = 0;
    bus.req_b = 1; bus.addr_b = 4'hF; bus.data_b = 16'h00FF;
    @(negedge clk);
    chk("df_wr_en", bus.wr_en, 1);
    chk("df_data1", bus.wr_data, 16'h4321);
    chk("b_gnt", bus.gnt_b, 1);
    chk("b_sel", bus.sel, 1);
    cyc();
    bus.req_b = 0;
    bus.req_a = 1; bus.addr_a = 4'h7; bus.data_a = 16'h0A0A;
    @(negedge clk);
    chk("b_addr", bus.wr_addr, 4'hF);
    chk("b_data", bus.wr_data, 16'h00FF);
    chk("a2_gnt", bus.gnt_a, 1);
    cyc();
    bus.req_a = 0;
    @(negedge clk);
    chk("a2_data", bus.wr_data, 16'h0A0A);
    cyc();
    @(negedge clk);
    chk("a2_idle", bus.wr_en, 0);
    cyc();

    // random protocol-legal traffic
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      ga = bus.gnt_a;
      gb = bus.gnt_b;
      cyc();
      if (ga || !bus.req_a) begin
        bus.req_a = 1'($urandom_range(0, 1));
        bus.addr_a = 4'($urandom);
        bus.data_a = 16'($urandom);
      end
      if (gb || !bus.req_b) begin
        bus.req_b = 1'($urandom_range(0, 1));
        bus.addr_b = 4'($urandom);
        bus.data_b = 16'($urandom);
      end
      bus.wr_rdy = ($urandom_range(0, 9) < 7);
    end
    bus.wr_rdy = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ga = bus.gnt_a;
      gb = bus.gnt_b;
      cyc();
      if (ga) bus.req_a = 0;
      if (gb) bus.req_b = 0;
    end
    bus.req_a = 0;
    bus.req_b = 0;

    // asynchronous reset while FULL
    bus.req_a = 1; bus.addr_a = 4'h9; bus.data_a = 16'hBEEF;
    @(negedge clk);
    chk("r_gnt", bus.gnt_a, 1);
    cyc();
    bus.req_a = 0;
    bus.wr_rdy = 0;
    @(negedge clk);
    chk("r_full", bus.wr_data, 16'hBEEF);
    #1;
    bus.req_a = 1; bus.addr_a = 4'h2; bus.data_a = 16'h1111;
    rst_f = 0;
    #1;
    chk("r_wr_en", bus.wr_en, 0);
    chk("r_addr", bus.wr_addr, 0);
    chk("r_data", bus.wr_data, 0);
    chk("r_gnt_a", bus.gnt_a, 0);
    chk("r_gnt_b", bus.gnt_b, 0);
    @(negedge clk);
    cyc();
    rst_f = 1;
    bus.wr_rdy = 1;
    @(negedge clk);
    chk("r_after", bus.gnt_a, 1);
    cyc();
    bus.req_a = 0;
    @(negedge clk);
    chk("r_after_data", bus.wr_data, 16'h1111);
    cyc();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
